fp_div_iter: RTL and testbench

FP_DIV_ITER -- requirements
Module: fp_div_iter

---
 rtl/fp_div_iter.sv | 171 +++++++++++++++++
 tb/tb_fp_div_iter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fp_div_iter.sv
// Iterative IEEE-754 single-precision divider: one restoring quotient bit per cycle,
// truncating result, zero/inf/NaN handled by an early-out classification at start.
module fp_div_iter (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] N,
   input  logic [31:0] D,
   output logic        busy,
   output logic        done,
   output logic [31:0] Q,
   output logic        dz
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ITER = 2'd1;
   localparam logic [1:0] NORM = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]         state;
   logic [1:0]         state_nxt;
   logic               sign;
   logic signed [9:0]  e;
   logic [24:0]        r;
   logic [23:0]        md;
   logic [24:0]        q;
   logic [4:0]         cnt;
   logic               special;
   logic [31:0]        spec_q;
   logic               spec_dz;

   logic               cls_special;
   logic [31:0]        cls_q;
   logic               cls_dz;
   logic               sign_in;

   logic               ge;
   logic [24:0]        r_step;
   logic [24:0]        q_step;

   logic signed [9:0]  exp_n;
   logic [22:0]        mant_n;
   logic [31:0]        norm_q;

   assign sign_in = N[31] ^ D[31];

   // Operand classification; priority NaN/inf, then zero divisor, then zero dividend.
   always_comb begin
      cls_special = 1'b0;
      cls_q       = 32'h0000_0000;
      cls_dz      = 1'b0;
      if ((N[30:23] == 8'hFF) || (D[30:23] == 8'hFF)) begin
         cls_special = 1'b1;
         cls_q       = 32'h7FC0_0000;
      end else if (D[30:23] == 8'h00) begin
         cls_special = 1'b1;
         cls_q       = {sign_in, 8'hFF, 23'd0};
         cls_dz      = 1'b1;
      end else if (N[30:23] == 8'h00) begin
         cls_special = 1'b1;
         cls_q       = {sign_in, 31'd0};
      end else begin
         cls_special = 1'b0;
      end
   end

   // One restoring step; r stays below 2*md so the shifted difference fits in 25 bits.
   always_comb begin
      ge = (r >= {1'b0, md});
      if (ge) begin
         r_step = (r - {1'b0, md}) << 1;
      end else begin
         r_step = r << 1;
      end
      q_step = {q[23:0], ge};
   end

   // Normalisation and exponent range check of the finished quotient.
   always_comb begin
      if (q[24]) begin
         mant_n = q[23:1];
         exp_n  = e;
      end else begin
         mant_n = q[22:0];
         exp_n  = e - 10'sd1;
      end
      if (exp_n >= 10'sd255) begin
         norm_q = {sign, 8'hFF, 23'd0};
      end else if (exp_n <= 10'sd0) begin
         norm_q = {sign, 31'd0};
      end else begin
         norm_q = {sign, exp_n[7:0], mant_n};
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = cls_special ? NORM : ITER;
            end else begin
               state_nxt = IDLE;
            end
         end
         ITER: begin
            if (cnt == 5'd24) begin
               state_nxt = NORM;
            end else begin
               state_nxt = ITER;
            end
         end
         NORM:    state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath and output registers; done is registered so it pulses in the first IDLE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         Q       <= 32'd0;
         dz      <= 1'b0;
         sign    <= 1'b0;
         e       <= 10'sd0;
         r       <= 25'd0;
         md      <= 24'd0;
         q       <= 25'd0;
         cnt     <= 5'd0;
         special <= 1'b0;
         spec_q  <= 32'd0;
         spec_dz <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != IDLE);
         done  <= (state == DONE);
         case (state)
            IDLE: begin
               if (start) begin
                  sign    <= sign_in;
                  e       <= $signed({2'b00, N[30:23]} - {2'b00, D[30:23]} + 10'd127);
                  r       <= {2'b01, N[22:0]};
                  md      <= {1'b1, D[22:0]};
                  q       <= 25'd0;
                  cnt     <= 5'd0;
                  special <= cls_special;
                  spec_q  <= cls_q;
                  spec_dz <= cls_dz;
                  dz      <= 1'b0;
               end
            end
            ITER: begin
               q   <= q_step;
               r   <= r_step;
               cnt <= cnt + 5'd1;
            end
            NORM: begin
               Q  <= special ? spec_q : norm_q;
               dz <= special ? spec_dz : 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_div_iter.sv
// Self-checking bench for fp_div_iter: directed corner cases plus random operands
// compared against an integer-division reference model.
module tb_fp_div_iter;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] N;
   logic [31:0] D;
   logic        busy;
   logic        done;
   logic [31:0] Q;
   logic        dz;

   int n_cmp;
   int n_bad;

   fp_div_iter dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .N     (N),
      .D     (D),
      .busy  (busy),
      .done  (done),
      .Q     (Q),
      .dz    (dz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: quotient of the real mantissas by exact integer division, truncated.
   task automatic ref_div(input logic [31:0] n, input logic [31:0] d,
                          output logic [31:0] eq, output logic edz, output int elat);
      int          ne, de, ex;
      logic        s;
      longint      mn, mdv, quo, mant;
      ne = int'(n[30:23]);
      de = int'(d[30:23]);
      s  = n[31] ^ d[31];
      edz  = 1'b0;
      elat = 2;
      if (ne == 255 || de == 255) begin
         eq = 32'h7FC0_0000;
      end else if (de == 0) begin
         eq  = {s, 8'hFF, 23'd0};
         edz = 1'b1;
      end else if (ne == 0) begin
         eq = {s, 31'd0};
      end else begin
         elat = 27;
         mn   = longint'({1'b1, n[22:0]});
         mdv  = longint'({1'b1, d[22:0]});
         quo  = (mn * 64'sd16777216) / mdv;
         ex   = ne - de + 127;
         if (quo >= 64'sd16777216) begin
            mant = (quo / 2) % 64'sd8388608;
         end else begin
            mant = quo % 64'sd8388608;
            ex   = ex - 1;
         end
         if (ex >= 255) begin
            eq = {s, 8'hFF, 23'd0};
         end else if (ex <= 0) begin
            eq = {s, 31'd0};
         end else begin
            eq = {s, ex[7:0], mant[22:0]};
         end
      end
   endtask

   // Issue one operation; optionally re-pulse start at cycle 'inject' while busy.
   task automatic do_op(input logic [31:0] n, input logic [31:0] d, input int inject);
      logic [31:0] eq;
      logic        edz;
      int          elat;
      int          k;
      bit          seen;
      ref_div(n, d, eq, edz, elat);
      @(negedge clk);
      N = n; D = d; start = 1'b1;
      @(negedge clk);
      start = 1'b0; N = $urandom; D = $urandom;
      check("busy_after_start", {31'd0, busy}, 32'd1);
      k = 0;
      seen = 1'b0;
      while (k < 40 && !seen) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            start = (k == inject);
            N = $urandom; D = $urandom;
            @(negedge clk);
            k++;
         end
      end
      start = 1'b0;
      check("done_seen", {31'd0, seen}, 32'd1);
      check("latency", k, elat);
      check("q", Q, eq);
      check("dz", {31'd0, dz}, {31'd0, edz});
      check("busy_at_done", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("q_hold", Q, eq);
   endtask

   initial begin
      logic [31:0] rn, rd;
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1; start = 1'b0; N = 32'd0; D = 32'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_q", Q, 32'd0);
      check("rst_dz", {31'd0, dz}, 32'd0);

      do_op(32'h40C0_0000, 32'h4000_0000, -1);
      check("six_div_two", Q, 32'h4040_0000);
      do_op(32'h3F80_0000, 32'h4040_0000, -1);
      check("one_third", Q, 32'h3EAA_AAAA);
      do_op(32'hBFC0_0000, 32'h3F00_0000, -1);
      check("neg_case", Q, 32'hC040_0000);
      do_op(32'h3F80_0000, 32'h0000_0000, -1);
      check("div_zero", Q, 32'h7F80_0000);
      check("div_zero_dz", {31'd0, dz}, 32'd1);
      do_op(32'h7F80_0000, 32'h3F80_0000, -1);
      check("nan_case", Q, 32'h7FC0_0000);
      do_op(32'h0000_0000, 32'hC000_0000, -1);
      do_op(32'h7F00_0000, 32'h0080_0000, -1);
      check("overflow", Q, 32'h7F80_0000);
      do_op(32'h0080_0000, 32'h7F00_0000, -1);
      check("underflow", Q, 32'h0000_0000);

      // Start pulse mid-ITER must be ignored.
      do_op(32'h40C0_0000, 32'h4000_0000, 5);
      check("inject_ignored", Q, 32'h4040_0000);

      // Reset in the middle of ITER aborts cleanly.
      @(negedge clk);
      N = 32'h3F80_0000; D = 32'h4040_0000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_q", Q, 32'd0);
      check("midrst_dz", {31'd0, dz}, 32'd0);
      do_op(32'h40C0_0000, 32'h4000_0000, -1);
      check("after_rst", Q, 32'h4040_0000);

      for (int i = 0; i < 60; i++) begin
         rn = $urandom;
         rd = $urandom;
         case ($urandom_range(0, 9))
            0:       rn[30:23] = 8'h00;
            1:       rd[30:23] = 8'h00;
            2:       rd[30:23] = 8'hFF;
            default: begin
            end
         endcase
         do_op(rn, rd, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
